// File: rtl/timer_device_if.sv
// Bus port bundle between the bus decoder (master) and the timer device (slave).
interface timer_device_if;
  logic        write_enable;
  logic        control;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;

  modport master (
    output write_enable, control, address, data_in,
    input  data_out, irq
  );

  modport slave (
    input  write_enable, control, address, data_in,
    output data_out, irq
  );
endinterface

// File: rtl/timer_device.sv
// Prescaled down-counting timer with optional reload, expiry flag and level interrupt.
module timer_device #(
  parameter logic [15:0] DEVICE_ID = 16'h0300
) (
  input  logic          clock,
  input  logic          reset,
  timer_device_if.slave bus
);

  localparam int DATA_W = 16;

  localparam logic [3:0] A_ID     = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_CTRL   = 4'd2;
  localparam logic [3:0] A_PRE    = 4'd3;
  localparam logic [3:0] A_RELOAD = 4'd4;
  localparam logic [3:0] A_COUNT  = 4'd5;

  logic [DATA_W-1:0] r_data_out;
  logic              r_expired;
  logic              r_en;
  logic              r_reload;
  logic              r_irq_en;
  logic [DATA_W-1:0] r_prescale;
  logic [DATA_W-1:0] r_reload_val;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_pre_cnt;

  logic [3:0]        w_addr;
  logic              w_wr;
  logic              w_wr_status;
  logic              w_wr_ctrl;
  logic              w_wr_pre;
  logic              w_wr_reload;
  logic              w_wr_count;
  logic              w_tick;
  logic              w_expire;
  logic              w_en_nxt;
  logic              w_pre_clr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused;

  // Only the low nibble of the word offset selects a register.
  assign w_addr   = bus.address[3:0];
  assign w_unused = ^bus.address[7:4];

  assign w_wr        = bus.write_enable & bus.control;
  assign w_wr_status = w_wr && (w_addr == A_STATUS);
  assign w_wr_ctrl   = w_wr && (w_addr == A_CTRL);
  assign w_wr_pre    = w_wr && (w_addr == A_PRE);
  assign w_wr_reload = w_wr && (w_addr == A_RELOAD);
  assign w_wr_count  = w_wr && (w_addr == A_COUNT);

  assign w_tick   = r_en && (r_pre_cnt == r_prescale);
  assign w_expire = w_tick && (r_count == '0);

  // A CTRL write overrides the hardware EN clear of a one-shot expiry.
  always_comb begin
    w_en_nxt = r_en;
    if (w_wr_ctrl)
      w_en_nxt = bus.data_in[0];
    else if (w_expire && !r_reload)
      w_en_nxt = 1'b0;
  end

  assign w_pre_clr = !w_en_nxt || w_tick || w_wr_pre ||
                     (w_wr_ctrl && bus.data_in[0] && !r_en);

  always_comb begin
    w_rd_data = '0;
    if (bus.control) begin
      case (w_addr)
        A_ID:     w_rd_data = DEVICE_ID;
        A_STATUS: w_rd_data = {{(DATA_W-1){1'b0}}, r_expired};
        A_CTRL:   w_rd_data = {{(DATA_W-3){1'b0}}, r_irq_en, r_reload, r_en};
        A_PRE:    w_rd_data = r_prescale;
        A_RELOAD: w_rd_data = r_reload_val;
        A_COUNT:  w_rd_data = r_count;
        default:  w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out   <= '0;
      r_expired    <= 1'b0;
      r_en         <= 1'b0;
      r_reload     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_prescale   <= '0;
      r_reload_val <= '0;
      r_count      <= '0;
      r_pre_cnt    <= '0;
    end else begin
      r_data_out <= w_rd_data;
      r_en       <= w_en_nxt;

      if (w_pre_clr)
        r_pre_cnt <= '0;
      else
        r_pre_cnt <= r_pre_cnt + 1'b1;

      if (w_wr_ctrl) begin
        r_reload <= bus.data_in[1];
        r_irq_en <= bus.data_in[2];
      end

      if (w_wr_pre)
        r_prescale <= bus.data_in;
      if (w_wr_reload)
        r_reload_val <= bus.data_in;

      // A bus write to COUNT beats a same-cycle decrement or reload.
      if (w_wr_count)
        r_count <= bus.data_in;
      else if (w_tick) begin
        if (r_count != '0)
          r_count <= r_count - 1'b1;
        else if (r_reload)
          r_count <= r_reload_val;
      end

      // Expiry wins over a same-cycle W1C clear.
      if (w_expire)
        r_expired <= 1'b1;
      else if (w_wr_status && bus.data_in[0])
        r_expired <= 1'b0;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.irq      = r_expired & r_irq_en;

endmodule

// File: tb/tb_timer_device.sv
// Table-driven and sequence bench for timer_device with a read-data scoreboard.
module tb_timer_device;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_device_if bus();

  timer_device #(.DEVICE_ID(16'h0300)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        ctl;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_do;
    logic        exp_irq;
  } vec_t;

  typedef struct packed {
    logic [15:0] exp_do;
    logic        exp_irq;
  } sb_t;

  sb_t   sbq[$];
  string nmq[$];
  vec_t  tbl[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic vec_t mk(input logic r, input logic we, input logic c,
                              input logic [7:0] a, input logic [15:0] d,
                              input logic [15:0] e, input logic i);
    vec_t v;
    v.rst = r; v.we = we; v.ctl = c; v.addr = a; v.din = d;
    v.exp_do = e; v.exp_irq = i;
    return v;
  endfunction

  // Compare the outputs produced by the previous cycle's stimulus.
  task automatic check_pending();
    sb_t   e;
    string n;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    n = nmq.pop_front();
    checks++;
    if (bus.data_out !== e.exp_do) begin
      failures++;
      $display("FAIL %s data_out got=%h exp=%h", n, bus.data_out, e.exp_do);
    end
    checks++;
    if (bus.irq !== e.exp_irq) begin
      failures++;
      $display("FAIL %s irq got=%b exp=%b", n, bus.irq, e.exp_irq);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    sb_t e;
    @(negedge clk);
    check_pending();
    rst              = v.rst;
    bus.write_enable = v.we;
    bus.control      = v.ctl;
    bus.address      = v.addr;
    bus.data_in      = v.din;
    e.exp_do  = v.exp_do;
    e.exp_irq = v.exp_irq;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  initial begin
    logic [15:0] exp_cnt;
    rst              = 1'b1;
    bus.write_enable = 1'b0;
    bus.control      = 1'b0;
    bus.address      = 8'h00;
    bus.data_in      = 16'h0000;

    step(mk(1, 0, 0, 8'h00, 16'h0000, 16'h0000, 0), "reset0");
    step(mk(1, 0, 0, 8'h00, 16'h0000, 16'h0000, 0), "reset1");

    // Register map, decode and write-qualification vectors.
    tbl.push_back(mk(0, 0, 1, 8'h00, 16'h0000, 16'h0300, 0));
    tbl.push_back(mk(0, 0, 1, 8'h07, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h03, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 8'h03, 16'hABCD, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h03, 16'h0000, 16'hABCD, 0));
    tbl.push_back(mk(0, 1, 1, 8'h04, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 16'h0000, 16'h1234, 0));
    tbl.push_back(mk(0, 1, 0, 8'h04, 16'hFFFF, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 16'h0000, 16'h1234, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 16'h5555, 16'h1234, 0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 16'h0000, 16'h1234, 0));
    tbl.push_back(mk(0, 0, 1, 8'h13, 16'h0000, 16'hABCD, 0));
    tbl.push_back(mk(0, 1, 1, 8'h02, 16'hFFF8, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 16'h1111, 16'h0300, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 16'h0000, 16'h0300, 0));
    tbl.push_back(mk(0, 1, 1, 8'h07, 16'hFFFF, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h07, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 8'hF5, 16'h0042, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0042, 0));
    tbl.push_back(mk(0, 1, 1, 8'h03, 16'h0000, 16'hABCD, 0));
    tbl.push_back(mk(0, 1, 1, 8'h05, 16'h0003, 16'h0042, 0));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("tbl%0d", i));

    // One-shot countdown with interrupt enabled, PRESCALE=0, COUNT=3.
    step(mk(0, 1, 1, 8'h02, 16'h0005, 16'h0000, 0), "os_start");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0003, 0), "os_cnt3");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0002, 0), "os_cnt2");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0001, 0), "os_cnt1");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0000, 1), "os_cnt0_exp");
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0004, 1), "os_en_clr");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0001, 1), "os_status");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0000, 1), "os_hold0");
    step(mk(0, 1, 1, 8'h01, 16'h0001, 16'h0001, 0), "os_w1c");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0000, 0), "os_w1c_rd");

    // Periodic reload: PRESCALE=2, RELOAD_VAL=1, COUNT=1.
    step(mk(0, 1, 1, 8'h03, 16'h0002, 16'h0000, 0), "rl_pre");
    step(mk(0, 1, 1, 8'h04, 16'h0001, 16'h1234, 0), "rl_rval");
    step(mk(0, 1, 1, 8'h05, 16'h0001, 16'h0000, 0), "rl_cnt");
    step(mk(0, 1, 1, 8'h02, 16'h0003, 16'h0004, 0), "rl_start");
    for (int j = 0; j < 12; j++) begin
      exp_cnt = (((j / 3) % 2) == 0) ? 16'h0001 : 16'h0000;
      step(mk(0, 0, 1, 8'h05, 16'h0000, exp_cnt, 0), $sformatf("rl_cnt_c%0d", j + 1));
    end
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0003, 0), "rl_en_stays");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0001, 0), "rl_expired");

    // Stop, then run a 2-cycle periodic timer to exercise W1C vs expiry.
    step(mk(0, 1, 1, 8'h02, 16'h0000, 16'h0003, 0), "c_stop");
    step(mk(0, 1, 1, 8'h01, 16'h0001, 16'h0001, 0), "c_clr");
    step(mk(0, 1, 1, 8'h03, 16'h0000, 16'h0002, 0), "c_pre");
    step(mk(0, 1, 1, 8'h04, 16'h0001, 16'h0001, 0), "c_rval");
    step(mk(0, 1, 1, 8'h05, 16'h0001, 16'h0000, 0), "c_cnt");
    step(mk(0, 1, 1, 8'h02, 16'h0007, 16'h0000, 0), "c_start");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0000, 0), "c_noexp");
    step(mk(0, 1, 1, 8'h01, 16'h0001, 16'h0000, 1), "c_w1c_on_expiry");
    step(mk(0, 1, 1, 8'h01, 16'h0001, 16'h0001, 0), "c_w1c_no_expiry");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0000, 1), "c_reexpire");
    step(mk(0, 1, 1, 8'h05, 16'h00FF, 16'h0001, 1), "c_cnt_wr_tick");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h00FF, 1), "c_cnt_wr_wins");
    step(mk(0, 1, 0, 8'h05, 16'h1234, 16'h0000, 1), "c_dspace_wr");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h00FD, 1), "c_dspace_nochg");

    // Reset mid-count with irq asserted and a competing write.
    step(mk(1, 1, 1, 8'h05, 16'h5555, 16'h0000, 0), "r_mid");
    step(mk(0, 0, 1, 8'h05, 16'h0000, 16'h0000, 0), "r_count");
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0000, 0), "r_ctrl");
    step(mk(0, 0, 1, 8'h03, 16'h0000, 16'h0000, 0), "r_pre");
    step(mk(0, 0, 1, 8'h04, 16'h0000, 16'h0000, 0), "r_rval");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0000, 0), "r_status");
    step(mk(0, 0, 1, 8'h00, 16'h0000, 16'h0300, 0), "r_id");
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0000, 0), "r_idle");

    // CTRL write in the expiry cycle keeps EN set; the next expiry clears it.
    step(mk(0, 1, 1, 8'h02, 16'h0001, 16'h0000, 0), "p_start");
    step(mk(0, 1, 1, 8'h02, 16'h0001, 16'h0001, 0), "p_wr_on_expiry");
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0001, 0), "p_en_kept");
    step(mk(0, 0, 1, 8'h02, 16'h0000, 16'h0000, 0), "p_en_cleared");
    step(mk(0, 0, 1, 8'h01, 16'h0000, 16'h0001, 0), "p_expired");

    @(negedge clk);
    check_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
